// File: rtl/popcount_stream_pkg.sv
// Shared types and width helpers for the streaming popcount block.
// Holds the beat-mode encodings and the per-beat control record.
// Widths derive from the element counts at elaboration time.
package popcount_stream_pkg;

   localparam logic MODE_WORD = 1'b0;   // each beat produces its own count
   localparam logic MODE_ACC  = 1'b1;   // beats sum until the frame's last beat

   // Bits needed to hold a count of 0..n inclusive.
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

   // Control bits that travel alongside the chunk counts through S1.
   typedef struct packed {
      logic last;
      logic mode;
   } beat_ctl_t;

endpackage

// File: rtl/popcount_stream_if.sv
// Input and output handshake bundle of the streaming popcount block.
// master drives beats and consumer ready; slave is the counting engine.
// O_count width follows the accumulator width of the attached engine.
interface popcount_stream_if #(
   parameter int WIDTH = 32,
   parameter int ACC_W = 16
);
   logic             I_valid;
   logic             I_ready;
   logic [WIDTH-1:0] I_data;
   logic             I_last;
   logic             I_mode;
   logic             O_valid;
   logic             O_ready;
   logic [ACC_W-1:0] O_count;
   logic             O_sat;

   modport master (
      output I_valid, I_data, I_last, I_mode, O_ready,
      input  I_ready, O_valid, O_count, O_sat
   );

   modport slave (
      input  I_valid, I_data, I_last, I_mode, O_ready,
      output I_ready, O_valid, O_count, O_sat
   );
endinterface

// File: rtl/popcount_stream_chunk.sv
// Purpose: popcount of one CHUNK-bit slice of the input vector.
// Latency: purely combinational, zero cycles.
// Backpressure: none; it is evaluated every cycle in front of S1.
module popcount_stream_chunk
   import popcount_stream_pkg::*;
#(
   parameter  int CHUNK = 8,
   localparam int CW    = cnt_w(CHUNK)
) (
   input  logic [CHUNK-1:0] i_bits,
   output logic [CW-1:0]    o_cnt
);

   // Ripple sum of the slice bits; CHUNK is small so depth stays shallow.
   always_comb begin
      o_cnt = '0;
      for (int i = 0; i < CHUNK; i++) begin
         o_cnt = o_cnt + CW'(i_bits[i]);
      end
   end

endmodule

// File: rtl/popcount_stream.sv
// Purpose: streaming WIDTH-bit popcount with optional per-frame accumulation.
// Latency: 2 cycles accept-to-O_valid (mode 0, or the last beat of a mode-1 frame).
// Backpressure: S1/S2 skid through valid/ready; I_ready = !s1_valid | s2 advance.
module popcount_stream
   import popcount_stream_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8,
   parameter int ACC_W = 16
) (
   input logic               CLK,
   input logic               ASYNCRESET,
   popcount_stream_if.slave  bus
);

   localparam int NCH   = WIDTH / CHUNK;
   localparam int CW    = cnt_w(CHUNK);
   localparam int SUM_W = cnt_w(WIDTH);
   localparam int AW1   = ACC_W + 1;

   // Reject geometries where chunks do not tile the word or the result cannot fit.
   if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("popcount_stream: WIDTH must be a multiple of CHUNK");
   end
   if (ACC_W < SUM_W) begin : g_bad_accw
      $error("popcount_stream: ACC_W too narrow for a full-word count");
   end

   logic [NCH-1:0][CW-1:0] w_cnt;
   logic                   w_in_fire;
   logic                   w_s2_adv;
   logic [SUM_W-1:0]       w_sum;
   logic [AW1-1:0]         w_add;
   logic                   w_add_ovf;
   logic [ACC_W-1:0]       w_add_sat;

   logic                   r_s1_vld;
   logic [NCH-1:0][CW-1:0] r_s1_cnt;
   beat_ctl_t              r_s1_ctl;

   logic                   r_o_vld;
   logic [ACC_W-1:0]       r_o_cnt;
   logic                   r_o_sat;

   logic [ACC_W-1:0]       r_acc;
   logic                   r_ovf;

   for (genvar g = 0; g < NCH; g++) begin : g_chunk
      popcount_stream_chunk #(.CHUNK(CHUNK)) u_chunk (
         .i_bits (bus.I_data[g*CHUNK +: CHUNK]),
         .o_cnt  (w_cnt[g])
      );
   end

   // S2 moves whenever S1 holds a beat and the output slot is free or being drained.
   assign w_s2_adv    = r_s1_vld & (~r_o_vld | bus.O_ready);
   assign bus.I_ready = ~r_s1_vld | w_s2_adv;
   assign w_in_fire   = bus.I_valid & bus.I_ready;

   // Adder tree over the registered chunk counts, zero-extended so it is exact.
   always_comb begin
      w_sum = '0;
      for (int i = 0; i < NCH; i++) begin
         w_sum = w_sum + SUM_W'(r_s1_cnt[i]);
      end
   end

   // One extra bit catches overflow; both operands fit ACC_W so the sum fits AW1.
   assign w_add     = {1'b0, r_acc} + AW1'(w_sum);
   assign w_add_ovf = w_add[ACC_W];
   assign w_add_sat = w_add_ovf ? {ACC_W{1'b1}} : w_add[ACC_W-1:0];

   // S1: capture chunk counts and beat control on accept, hold while stalled.
   always_ff @(posedge CLK or posedge ASYNCRESET) begin
      if (ASYNCRESET) begin
         r_s1_vld <= 1'b0;
         r_s1_cnt <= '0;
         r_s1_ctl <= '0;
      end else if (w_in_fire) begin
         r_s1_vld <= 1'b1;
         r_s1_cnt <= w_cnt;
         r_s1_ctl <= '{last: bus.I_last, mode: bus.I_mode};
      end else if (w_s2_adv) begin
         r_s1_vld <= 1'b0;
      end
   end

   // S2 output register: emit word counts and frame totals, hold until taken.
   always_ff @(posedge CLK or posedge ASYNCRESET) begin
      if (ASYNCRESET) begin
         r_o_vld <= 1'b0;
         r_o_cnt <= '0;
         r_o_sat <= 1'b0;
      end else if (w_s2_adv) begin
         if (r_s1_ctl.mode == MODE_WORD) begin
            r_o_cnt <= ACC_W'(w_sum);
            r_o_sat <= 1'b0;
            r_o_vld <= 1'b1;
         end else if (r_s1_ctl.last) begin
            r_o_cnt <= w_add_sat;
            r_o_sat <= r_ovf | w_add_ovf;
            r_o_vld <= 1'b1;
         end else begin
            // Mid-frame beat: any previous result is being taken this cycle.
            r_o_vld <= 1'b0;
         end
      end else if (bus.O_ready) begin
         r_o_vld <= 1'b0;
      end
   end

   // Frame accumulator and sticky overflow; word-mode beats leave them alone.
   always_ff @(posedge CLK or posedge ASYNCRESET) begin
      if (ASYNCRESET) begin
         r_acc <= '0;
         r_ovf <= 1'b0;
      end else if (w_s2_adv && (r_s1_ctl.mode == MODE_ACC)) begin
         if (r_s1_ctl.last) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
         end else begin
            r_acc <= w_add_sat;
            r_ovf <= r_ovf | w_add_ovf;
         end
      end
   end

   assign bus.O_valid = r_o_vld;
   assign bus.O_count = r_o_cnt;
   assign bus.O_sat   = r_o_sat;

endmodule

// File: tb/tb_popcount_stream.sv
// Bench for popcount_stream: two instances (ACC_W 16 and 6) share one stimulus.
// A queue-based reference model built on $countones predicts every result.
// Directed scenarios first, then a randomized valid/ready soak.
module tb_popcount_stream;
   import popcount_stream_pkg::*;

   logic CLK        = 1'b0;
   logic ASYNCRESET = 1'b1;
   always #5 CLK = ~CLK;

   popcount_stream_if #(.WIDTH(32), .ACC_W(16)) bus_a ();
   popcount_stream_if #(.WIDTH(32), .ACC_W(6))  bus_b ();

   popcount_stream #(.WIDTH(32), .CHUNK(8), .ACC_W(16)) u_dut_a (
      .CLK(CLK), .ASYNCRESET(ASYNCRESET), .bus(bus_a.slave));
   popcount_stream #(.WIDTH(32), .CHUNK(8), .ACC_W(6)) u_dut_b (
      .CLK(CLK), .ASYNCRESET(ASYNCRESET), .bus(bus_b.slave));

   int     n_cmp = 0;
   int     n_bad = 0;
   int     exp_cnt [2][$];
   bit     exp_sat [2][$];
   int     obs_cnt [2][$];
   bit     obs_sat [2][$];
   int     obs_cyc [2][$];
   longint frame_sum [2];
   int     cyc_no = 0;
   bit     accepted;
   bit     smp_irdy;
   bit     smp_ovld;
   int     smp_ocnt;

   logic [31:0] t2_d [4] = '{32'h0, 32'h1, 32'h8000_0001, 32'hF0F0_F0F0};
   int          t2_e [4] = '{0, 1, 2, 16};
   logic [31:0] t5_d [3] = '{32'h7, 32'hFF, 32'hF};
   int          t5_e [3] = '{3, 8, 4};

   function automatic longint maxv(input int k);
      return (k == 0) ? 64'd65535 : 64'd63;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Scoreboard for one instance: retire outputs, then fold in any accepted beat.
   task automatic mon(input int k, input logic ov, input logic ordy, input logic [15:0] cnt,
                      input logic sat, input logic iv, input logic ir,
                      input logic [31:0] d, input logic m, input logic l);
      int c;
      int e;
      bit es;
      if (ov && ordy) begin
         if (exp_cnt[k].size() == 0) begin
            check($sformatf("spurious_out_%0d", k), 64'(ov), 64'd0);
         end else begin
            e  = exp_cnt[k].pop_front();
            es = exp_sat[k].pop_front();
            check($sformatf("count_%0d", k), 64'(cnt), 64'(e));
            check($sformatf("sat_%0d", k), 64'(sat), 64'(es));
            obs_cnt[k].push_back(int'(cnt));
            obs_sat[k].push_back(sat);
            obs_cyc[k].push_back(cyc_no);
         end
      end
      if (iv && ir) begin
         c = $countones(d);
         if (m == MODE_WORD) begin
            exp_cnt[k].push_back(c);
            exp_sat[k].push_back(1'b0);
         end else begin
            frame_sum[k] += c;
            if (l) begin
               exp_cnt[k].push_back(int'((frame_sum[k] > maxv(k)) ? maxv(k) : frame_sum[k]));
               exp_sat[k].push_back(frame_sum[k] > maxv(k));
               frame_sum[k] = 0;
            end
         end
      end
   endtask

   // One clock: sample at the falling edge, return just after the rising edge.
   task automatic cyc();
      @(negedge CLK);
      smp_irdy = bus_a.I_ready;
      smp_ovld = bus_a.O_valid;
      smp_ocnt = int'(bus_a.O_count);
      accepted = bus_a.I_valid && bus_a.I_ready;
      mon(0, bus_a.O_valid, bus_a.O_ready, bus_a.O_count, bus_a.O_sat,
          bus_a.I_valid, bus_a.I_ready, bus_a.I_data, bus_a.I_mode, bus_a.I_last);
      mon(1, bus_b.O_valid, bus_b.O_ready, 16'(bus_b.O_count), bus_b.O_sat,
          bus_b.I_valid, bus_b.I_ready, bus_b.I_data, bus_b.I_mode, bus_b.I_last);
      cyc_no++;
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic m, input logic l);
      bus_a.I_valid = v; bus_a.I_data = d; bus_a.I_mode = m; bus_a.I_last = l;
      bus_b.I_valid = v; bus_b.I_data = d; bus_b.I_mode = m; bus_b.I_last = l;
   endtask

   task automatic set_ordy(input logic r);
      bus_a.O_ready = r;
      bus_b.O_ready = r;
   endtask

   task automatic send(input logic [31:0] d, input logic m, input logic l, output int tries);
      drive(1'b1, d, m, l);
      tries = 0;
      do begin
         cyc();
         tries++;
      end while (!accepted && tries < 50);
      check("send_accept", 64'(accepted), 64'd1);
   endtask

   task automatic wait_outs(input int k, input int n, input string tag);
      int b = 0;
      while (obs_cnt[k].size() < n && b < 100) begin
         cyc();
         b++;
      end
      check(tag, 64'(obs_cnt[k].size() >= n), 64'd1);
   endtask

   task automatic clear_model();
      frame_sum[0] = 0;
      frame_sum[1] = 0;
      exp_cnt[0].delete(); exp_cnt[1].delete();
      exp_sat[0].delete(); exp_sat[1].delete();
   endtask

   initial begin
      int tries;
      int lat;
      int n0;
      int idx;
      int b;
      bit pend;
      logic [31:0] rd;

      drive(1'b0, 32'h0, 1'b0, 1'b0);
      set_ordy(1'b1);
      clear_model();

      // Reset state while reset is asserted.
      #12;
      check("rst_ovld", 64'(bus_a.O_valid), 64'd0);
      check("rst_ocnt", 64'(bus_a.O_count), 64'd0);
      check("rst_osat", 64'(bus_a.O_sat), 64'd0);
      check("rst_irdy", 64'(bus_a.I_ready), 64'd1);
      @(negedge CLK);
      ASYNCRESET = 1'b0;
      @(posedge CLK);
      #1;

      // T1: single all-ones word, two-cycle latency.
      send(32'hFFFF_FFFF, MODE_WORD, 1'b0, tries);
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      n0  = obs_cnt[0].size();
      lat = 0;
      while (obs_cnt[0].size() == n0 && lat < 10) begin
         cyc();
         lat++;
      end
      check("t1_latency", 64'(lat), 64'd2);
      check("t1_count", 64'(obs_cnt[0][n0]), 64'd32);
      check("t1_sat", 64'(obs_sat[0][n0]), 64'd0);

      // T2: back-to-back word counts at full rate.
      n0 = obs_cnt[0].size();
      for (int i = 0; i < 4; i++) begin
         send(t2_d[i], MODE_WORD, 1'b0, tries);
         check("t2_b2b_accept", 64'(tries), 64'd1);
      end
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      wait_outs(0, n0 + 4, "t2_drain");
      for (int i = 0; i < 4; i++) check("t2_count", 64'(obs_cnt[0][n0+i]), 64'(t2_e[i]));
      for (int i = 1; i < 4; i++) check("t2_consecutive", 64'(obs_cyc[0][n0+i] - obs_cyc[0][n0+i-1]), 64'd1);

      // T3: three-beat accumulate frame yields one result.
      n0 = obs_cnt[0].size();
      send(32'hFF,   MODE_ACC, 1'b0, tries);
      send(32'hFFFF, MODE_ACC, 1'b0, tries);
      send(32'h1,    MODE_ACC, 1'b1, tries);
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      wait_outs(0, n0 + 1, "t3_drain");
      repeat (3) cyc();
      check("t3_nout", 64'(obs_cnt[0].size() - n0), 64'd1);
      check("t3_count", 64'(obs_cnt[0][n0]), 64'd25);
      check("t3_sat", 64'(obs_sat[0][n0]), 64'd0);

      // T4: saturation on the narrow instance, then a clean single-beat frame.
      n0 = obs_cnt[1].size();
      send(32'hFFFF_FFFF, MODE_ACC, 1'b0, tries);
      send(32'hFFFF_FFFF, MODE_ACC, 1'b0, tries);
      send(32'hFFFF_FFFF, MODE_ACC, 1'b1, tries);
      send(32'h3,         MODE_ACC, 1'b1, tries);
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      wait_outs(1, n0 + 2, "t4_drain");
      check("t4_sat_count", 64'(obs_cnt[1][n0]), 64'd63);
      check("t4_sat_flag", 64'(obs_sat[1][n0]), 64'd1);
      check("t4_next_count", 64'(obs_cnt[1][n0+1]), 64'd2);
      check("t4_next_flag", 64'(obs_sat[1][n0+1]), 64'd0);

      // T5: consumer stalls for 5 cycles with 3 beats offered.
      n0 = obs_cnt[0].size();
      set_ordy(1'b0);
      idx = 0;
      drive(1'b1, t5_d[0], MODE_WORD, 1'b0);
      repeat (5) begin
         cyc();
         if (accepted) begin
            idx++;
            if (idx < 3) drive(1'b1, t5_d[idx], MODE_WORD, 1'b0);
            else drive(1'b0, 32'h0, 1'b0, 1'b0);
         end
      end
      check("t5_irdy_low", 64'(smp_irdy), 64'd0);
      check("t5_accepted_two", 64'(idx), 64'd2);
      check("t5_hold_vld", 64'(smp_ovld), 64'd1);
      check("t5_hold_cnt", 64'(smp_ocnt), 64'd3);
      set_ordy(1'b1);
      b = 0;
      while (idx < 3 && b < 20) begin
         cyc();
         b++;
         if (accepted) begin
            idx++;
            drive(1'b0, 32'h0, 1'b0, 1'b0);
         end
      end
      check("t5_all_accepted", 64'(idx), 64'd3);
      wait_outs(0, n0 + 3, "t5_drain");
      for (int i = 0; i < 3; i++) check("t5_order", 64'(obs_cnt[0][n0+i]), 64'(t5_e[i]));

      // T6: reset mid-frame discards the frame and clears outputs at once.
      send(32'hFF, MODE_ACC, 1'b0, tries);
      send(32'hF,  MODE_ACC, 1'b0, tries);
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      cyc();
      cyc();
      ASYNCRESET = 1'b1;
      #1;
      check("t6_rst_ovld", 64'(bus_a.O_valid), 64'd0);
      check("t6_rst_ocnt_a", 64'(bus_a.O_count), 64'd0);
      check("t6_rst_ocnt_b", 64'(bus_b.O_count), 64'd0);
      check("t6_rst_osat", 64'(bus_a.O_sat), 64'd0);
      clear_model();
      @(negedge CLK);
      ASYNCRESET = 1'b0;
      @(posedge CLK);
      #1;
      n0 = obs_cnt[0].size();
      send(32'h7, MODE_ACC, 1'b1, tries);
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      wait_outs(0, n0 + 1, "t6_drain");
      check("t6_fresh_frame", 64'(obs_cnt[0][n0]), 64'd3);

      // Randomized soak: random gaps, modes, frame ends and consumer stalls.
      pend = 1'b0;
      for (int i = 0; i < 800; i++) begin
         if (!pend && $urandom_range(0, 3) != 0) begin
            case ($urandom_range(0, 3))
               0: rd = $urandom;
               1: rd = 32'hFFFF_FFFF;
               2: rd = $urandom & $urandom;
               default: rd = 32'h0;
            endcase
            drive(1'b1, rd, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
            pend = 1'b1;
         end
         set_ordy($urandom_range(0, 9) < 7);
         cyc();
         if (accepted) begin
            pend = 1'b0;
            drive(1'b0, 32'h0, 1'b0, 1'b0);
         end
      end
      set_ordy(1'b1);
      b = 0;
      while (pend && b < 50) begin
         cyc();
         b++;
         if (accepted) pend = 1'b0;
      end
      check("rand_pending_accepted", 64'(pend), 64'd0);
      send(32'h0, MODE_ACC, 1'b1, tries);
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      repeat (10) cyc();
      check("rand_drain_a", 64'(exp_cnt[0].size()), 64'd0);
      check("rand_drain_b", 64'(exp_cnt[1].size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Absolute time limit so a wedged run still ends with a report.
   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
